logic_element_k: RTL and testbench
==================================

Name: logic_element_k

Overview:
- Parametrised successor of the current 2-input logic element.
- K-input LUT with an optional output register. The register has clock enable, synchronous clear and a configurable init value.
- Configuration is loaded serially through a shift chain, so logic elements in a tile can be daisy-chained.
- Instantiated per tile slot by the tile generator; the chain is driven by the bitstream loader.

Parameters:
- LUT_K, 4, number of LUT inputs (legal range 2..6).
- CFG_W, 2**LUT_K + 4, configuration word width. Derived; never overridden.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- enable  input  1  user clock enable for the output register.
- sclr  input  1  user synchronous clear. Loads the init value when allowed by config.
- data_in  input  LUT_K  LUT inputs. data_in is the unsigned index into the truth table.
- data_out  output  1  element output.
- cfg_shift_en  input  1  config shift strobe.
- cfg_shift_in  input  1  serial config in, from the previous element.
- cfg_shift_out  output  1  serial config out, to the next element. Equals cfg[0].

Behaviour:
- Config register cfg[CFG_W-1:0] field map:
  - [2**K-1:0] = truth table.
  - bit 2**K = comb_out.
  - bit 2**K+1 = ff_init.
  - bit 2**K+2 = ce_used.
  - bit 2**K+3 = sclr_en.
- Reset (nreset low, asynchronous, no clock needed):
  - cfg = 0, ff = 0.
  - Hence data_out = 0 and cfg_shift_out = 0.
  - Releasing reset mid-shift does not resume the shift; the loader restarts it.
- Shift: on each edge with cfg_shift_en = 1, cfg <= {cfg_shift_in, cfg[CFG_W-1:1]}.
  - Word C is loaded by presenting C[0] first, over exactly CFG_W edges.
  - cfg_shift_out presents the old cfg[0] before each edge, so a chain of N elements is a CFG_W*N-bit shift register.
- LUT: lut_z = truth_table[data_in]. Purely combinational, zero latency.
- Register ff update priority per edge, highest first:
  1. cfg_shift_en = 1 -> ff <= ff_init bit of the post-shift config (cfg_next[2**K+1]). Once shifting ends, ff holds the new init value.
  2. sclr = 1 and sclr_en = 1 -> ff <= ff_init. This overrides enable.
  3. ce_used = 0, or enable = 1 -> ff <= lut_z.
  4. Otherwise hold.
- sclr with sclr_en = 0 is ignored.
- Output select:
  - data_out = comb_out ? lut_z : ff.
  - comb_out = 1 gives 0-cycle latency; comb_out = 0 gives 1-cycle latency.
- While shifting, data_out follows the partially shifted cfg. Downstream logic must ignore it until the loader deasserts cfg_shift_en.
- All-zero cfg (post-reset) gives a registered constant 0.
- Identical behaviour for every LUT_K. No X on data_out for any input once reset has been applied.

Test Plan (LUT_K=4, CFG_W=20):
1. Reset: load any config, run, then pull nreset low between edges.
   - Required: data_out = 0 and cfg_shift_out = 0 immediately, with no clock edge.
   - Required: after release with enable = 1 and data_in = 4'hF, data_out stays 0.
2. Combinational AND4: shift in truth = 16'h8000, comb_out = 1.
   - data_in = 4'hF -> data_out = 1 in the same cycle.
   - data_in = 4'hE -> data_out = 0.
3. Registered parity: truth = 16'h6996, comb_out = 0, ce_used = 1.
   - enable = 0, data_in = 4'h1 -> data_out holds 0 across 3 edges.
   - Raise enable -> data_out = 1 after exactly one edge.
   - data_in = 4'h3 -> data_out = 0 on the next edge.
4. Sync clear: ff_init = 1, sclr_en = 1, truth = 16'h0000, enable = 1.
   - sclr pulse for one cycle -> data_out = 1 for one cycle, then 0.
   - Reload with sclr_en = 0; sclr pulse -> data_out stays 0.
5. Chain: two elements, shift 40 bits carrying word A (for the downstream element) then word B (for the upstream one).
   - Upstream cfg = B, downstream cfg = A.
   - Upstream cfg_shift_out reproduces its previous cfg bits, LSB first, during the first 20 edges.
6. Shift during operation: enable = 1, toggle data_in while shifting a word with ff_init = 1, comb_out = 0.
   - data_out = 1 on the edge that completes the shift.
   - data_out then tracks the LUT after one further edge.

Source files
------------

// File: rtl/logic_element_k.sv
// K-input LUT logic element with optional output register and serially
// loaded configuration; elements daisy-chain through cfg_shift_in/cfg_shift_out.
module logic_element_k #(
  parameter  int LUT_K = 4,
  localparam int CFG_W = 2**LUT_K + 4
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             enable,
  input  logic             sclr,
  input  logic [LUT_K-1:0] data_in,
  output logic             data_out,
  input  logic             cfg_shift_en,
  input  logic             cfg_shift_in,
  output logic             cfg_shift_out
);

  localparam int TT_W = 2**LUT_K;

  logic [CFG_W-1:0] cfg;
  logic [CFG_W-1:0] cfg_shifted;
  logic [TT_W-1:0]  truth_table;
  logic             comb_out;
  logic             ff_init;
  logic             ce_used;
  logic             sclr_en;
  logic             lut_z;
  logic             ff;

  assign truth_table = cfg[TT_W-1:0];
  assign comb_out    = cfg[TT_W];
  assign ff_init     = cfg[TT_W+1];
  assign ce_used     = cfg[TT_W+2];
  assign sclr_en     = cfg[TT_W+3];

  assign cfg_shifted = {cfg_shift_in, cfg[CFG_W-1:1]};
  assign lut_z       = truth_table[data_in];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cfg <= '0;
    end else if (cfg_shift_en) begin
      cfg <= cfg_shifted;
    end
  end

  // Shifting preloads ff with the incoming init bit so the register
  // starts from its configured value the moment the load completes.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ff <= 1'b0;
    end else if (cfg_shift_en) begin
      ff <= cfg_shifted[TT_W+1];
    end else if (sclr && sclr_en) begin
      ff <= ff_init;
    end else if (!ce_used || enable) begin
      ff <= lut_z;
    end
  end

  assign data_out      = comb_out ? lut_z : ff;
  assign cfg_shift_out = cfg[0];

endmodule

// File: tb/tb_logic_element_k.sv
// Bench for logic_element_k: two chained elements driven by randomized and
// directed stimulus, checked against a bit-queue model of the config chain.
module tb_logic_element_k;

  localparam int K = 4;
  localparam int W = 20;

  logic         clock;
  logic         nreset;
  logic         enable;
  logic         sclr;
  logic [K-1:0] data_in;
  logic         cfg_shift_en;
  logic         cfg_shift_in;
  logic         up_out, up_so, dn_out, dn_so;

  logic_element_k #(.LUT_K(K)) dut_up (
    .clock(clock), .nreset(nreset), .enable(enable), .sclr(sclr),
    .data_in(data_in), .data_out(up_out), .cfg_shift_en(cfg_shift_en),
    .cfg_shift_in(cfg_shift_in), .cfg_shift_out(up_so)
  );

  logic_element_k #(.LUT_K(K)) dut_dn (
    .clock(clock), .nreset(nreset), .enable(enable), .sclr(sclr),
    .data_in(data_in), .data_out(dn_out), .cfg_shift_en(cfg_shift_en),
    .cfg_shift_in(up_so), .cfg_shift_out(dn_so)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: the two configs form one 40-bit shift chain;
  // index 0 is the downstream LSB, index 20 the upstream LSB
  bit chain_q[$];
  bit ff_m[2];

  function automatic bit cbit(int e, int i);
    return chain_q[(e == 0 ? W : 0) + i];
  endfunction

  function automatic bit model_out(int e, int din);
    return cbit(e, 16) ? cbit(e, din) : ff_m[e];
  endfunction

  task automatic model_reset();
    chain_q.delete();
    for (int i = 0; i < 2*W; i++) chain_q.push_back(1'b0);
    ff_m[0] = 1'b0;
    ff_m[1] = 1'b0;
  endtask

  task automatic model_edge(bit sh_en, bit sh_in, bit en, bit sc, int din);
    bit lz[2];
    for (int e = 0; e < 2; e++) lz[e] = cbit(e, din);
    if (sh_en) begin
      chain_q.push_back(sh_in);
      void'(chain_q.pop_front());
      for (int e = 0; e < 2; e++) ff_m[e] = cbit(e, 17);
    end else begin
      for (int e = 0; e < 2; e++) begin
        if (sc && cbit(e, 19)) ff_m[e] = cbit(e, 17);
        else if (!cbit(e, 18) || en) ff_m[e] = lz[e];
      end
    end
  endtask

  // scoreboard
  logic [3:0] exp_q[$];
  string      name_q[$];
  int         n_vec;
  int         n_err;

  task automatic push_expect(string name, int din);
    exp_q.push_back({model_out(0, din), cbit(0, 0), model_out(1, din), cbit(1, 0)});
    name_q.push_back(name);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    forever begin
      @(negedge clock);
      #2;
      while (exp_q.size() > 0) begin
        logic [3:0] exp_v;
        logic [3:0] act_v;
        string      nm;
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {up_out, up_so, dn_out, dn_so};
        n_vec++;
        if (act_v !== exp_v) begin
          n_err++;
          $display("FAIL %s: got {up_out,up_so,dn_out,dn_so}=%b expected %b", nm, act_v, exp_v);
        end
      end
    end
  end

  // driver tasks
  task automatic step(string name, bit sh_en, bit sh_in, bit en, bit sc, int din);
    @(negedge clock);
    cfg_shift_en = sh_en;
    cfg_shift_in = sh_in;
    enable       = en;
    sclr         = sc;
    data_in      = K'(din);
    #1;
    push_expect(name, din);
    @(posedge clock);
    model_edge(sh_en, sh_in, en, sc, din);
  endtask

  task automatic load_word(string name, logic [W-1:0] w);
    for (int i = 0; i < W; i++)
      step(name, 1'b1, w[i], 1'b1, 1'b0, int'($urandom_range(0, 15)));
  endtask

  task automatic async_reset(string name);
    @(negedge clock);
    cfg_shift_en = 1'b0;
    #1;
    nreset = 1'b0;
    model_reset();
    push_expect(name, int'(data_in));
    @(posedge clock);
    #1;
    nreset = 1'b1;
  endtask

  logic [W-1:0] word_a, word_b, word_r;

  initial begin
    nreset       = 1'b0;
    enable       = 1'b0;
    sclr         = 1'b0;
    data_in      = '0;
    cfg_shift_en = 1'b0;
    cfg_shift_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 nreset = 1'b1;

    step("post_reset", 1'b0, 1'b0, 1'b1, 1'b0, 15);

    // reset mid-operation, then hold zero with enable high
    load_word("rst_load", 20'h1_8000);
    step("rst_run", 1'b0, 1'b0, 1'b1, 1'b0, 15);
    async_reset("reset_async");
    for (int i = 0; i < 3; i++) step("rst_release", 1'b0, 1'b0, 1'b1, 1'b0, 15);

    // combinational AND4
    load_word("and4_load", 20'h1_8000);
    step("and4_f", 1'b0, 1'b0, 1'b0, 1'b0, 15);
    step("and4_e", 1'b0, 1'b0, 1'b0, 1'b0, 14);
    for (int i = 0; i < 8; i++) step("and4_rand", 1'b0, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 15)));

    // registered parity with clock enable
    load_word("par_load", 20'h4_6996);
    for (int i = 0; i < 3; i++) step("par_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1);
    step("par_en", 1'b0, 1'b0, 1'b1, 1'b0, 1);
    step("par_3", 1'b0, 1'b0, 1'b1, 1'b0, 3);
    step("par_after", 1'b0, 1'b0, 1'b1, 1'b0, 3);

    // synchronous clear enabled, then disabled
    load_word("sclr_load", 20'hA_0000);
    step("sclr_idle", 1'b0, 1'b0, 1'b1, 1'b0, 5);
    step("sclr_pulse", 1'b0, 1'b0, 1'b1, 1'b1, 5);
    step("sclr_one", 1'b0, 1'b0, 1'b1, 1'b0, 5);
    step("sclr_zero", 1'b0, 1'b0, 1'b1, 1'b0, 5);
    load_word("nosclr_load", 20'h2_0000);
    step("nosclr_idle", 1'b0, 1'b0, 1'b1, 1'b0, 5);
    step("nosclr_pulse", 1'b0, 1'b0, 1'b1, 1'b1, 5);
    step("nosclr_zero", 1'b0, 1'b0, 1'b1, 1'b0, 5);

    // chain: A for downstream, then B for upstream, then flush out
    word_a = W'($urandom);
    word_b = W'($urandom);
    load_word("chain_a", word_a);
    load_word("chain_b", word_b);
    for (int i = 0; i < 4; i++) step("chain_run", 1'b0, 1'b0, 1'b1, 1'b0, int'($urandom_range(0, 15)));
    for (int i = 0; i < 2*W; i++) step("chain_flush", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // shift during operation, init 1, registered output
    word_r = {4'b0010, 16'($urandom)};
    load_word("live_shift", word_r);
    for (int i = 0; i < 4; i++) step("live_track", 1'b0, 1'b0, 1'b1, 1'b0, int'($urandom_range(0, 15)));

    // random configs and operation, occasional shift bursts
    for (int n = 0; n < 25; n++) begin
      load_word("rand_load", W'($urandom));
      for (int i = 0; i < 30; i++)
        step("rand_run", ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)));
    end
    async_reset("reset_final");
    step("reset_final_run", 1'b0, 1'b0, 1'b1, 1'b0, 15);

    repeat (3) @(negedge clock);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule
